// File: rtl/clkmux_ctrl_pkg.sv
// Shared types and helpers for the clock-mux select sequencer.
package clkmux_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_OFF = 2'd1,
        WAIT_ON  = 2'd2,
        DONE     = 2'd3
    } state_e;

    localparam logic SRC_I0 = 1'b0;
    localparam logic SRC_I1 = 1'b1;

    // Width needed to hold 0..n for the settle counter.
    function automatic int settle_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/clkmux_sel_ctrl_if.sv
// Request/status and mux-pin bundle between the sequencer and its user.
interface clkmux_sel_ctrl_if;
    logic REQ;
    logic SEL;
    logic CLK0_OK;
    logic CLK1_OK;
    logic BUSY;
    logic ACK;
    logic ERR;
    logic CUR_SEL;
    logic CE0;
    logic CE1;
    logic S0;
    logic S1;
    logic IGNORE0;
    logic IGNORE1;

    modport master (
        output REQ, SEL, CLK0_OK, CLK1_OK,
        input  BUSY, ACK, ERR, CUR_SEL, CE0, CE1, S0, S1, IGNORE0, IGNORE1
    );

    modport slave (
        input  REQ, SEL, CLK0_OK, CLK1_OK,
        output BUSY, ACK, ERR, CUR_SEL, CE0, CE1, S0, S1, IGNORE0, IGNORE1
    );
endinterface

// File: rtl/clkmux_settle_cnt.sv
// Loadable down-counter with zero flag; one instance times both settle windows.
module clkmux_settle_cnt #(
    parameter int W = 4
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = load_val_i;
        else if (dec_i && (cnt_q != '0))
            cnt_d = cnt_q - W'(1);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

    assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/clkmux_sel_ctrl.sv
// Break-before-make sequencer for a glitch-free two-input clock mux.
// Optional CLKMUX_FORCE_SWITCH_EN: assert IGNOREn of a dead old source during a switch.
module clkmux_sel_ctrl
    import clkmux_ctrl_pkg::*;
#(
    parameter int SETTLE_CYCLES = 8,
    parameter bit INIT_SEL      = 1'b0
) (
    input logic               CLK,
    input logic               RST_N,
    clkmux_sel_ctrl_if.slave  bus
);
    localparam int          CW     = settle_w(SETTLE_CYCLES);
    localparam logic [1:0]  CE_RST = (INIT_SEL == SRC_I1) ? 2'b10 : 2'b01;

    state_e     state_q, state_d;
    logic [1:0] ce_q, ce_d;
    logic [1:0] ign_q, ign_d;
    logic       cur_sel_q, cur_sel_d;
    logic       sel_q, sel_d;
    logic       busy_q, busy_d;
    logic       ack_q, ack_d;
    logic       err_q, err_d;
    logic       cnt_load, cnt_dec, cnt_zero;
    logic [1:0] ok;

    assign ok = {bus.CLK1_OK, bus.CLK0_OK};

    clkmux_settle_cnt #(.W(CW)) u_cnt (
        .clk_i      (CLK),
        .rst_n_i    (RST_N),
        .load_i     (cnt_load),
        .load_val_i (CW'(SETTLE_CYCLES - 1)),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

    always_comb begin
        state_d   = state_q;
        ce_d      = ce_q;
        ign_d     = ign_q;
        cur_sel_d = cur_sel_q;
        sel_d     = sel_q;
        busy_d    = busy_q;
        ack_d     = 1'b0;
        err_d     = 1'b0;
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.REQ) begin
                    if (bus.SEL == cur_sel_q) begin
                        ack_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        ce_d[cur_sel_q] = 1'b0;
                        sel_d    = bus.SEL;
                        cnt_load = 1'b1;
                        busy_d   = 1'b1;
                        state_d  = WAIT_OFF;
`ifdef CLKMUX_FORCE_SWITCH_EN
                        if (!ok[cur_sel_q]) ign_d[cur_sel_q] = 1'b1;
`else
                        ign_d = '0;
`endif
                    end
                end
            end
            WAIT_OFF: begin
                if (cnt_zero) begin
                    ce_d[sel_q] = 1'b1;
                    cur_sel_d   = sel_q;
                    cnt_load    = 1'b1;
                    state_d     = WAIT_ON;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            WAIT_ON: begin
                if (cnt_zero) begin
                    // Outcome is registered on entry so it is visible during DONE.
                    ack_d   = ok[sel_q];
                    err_d   = !ok[sel_q];
                    busy_d  = 1'b0;
                    state_d = DONE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            DONE: begin
                ign_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= IDLE;
            ce_q      <= CE_RST;
            ign_q     <= '0;
            cur_sel_q <= INIT_SEL;
            sel_q     <= INIT_SEL;
            busy_q    <= 1'b0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ce_q      <= ce_d;
            ign_q     <= ign_d;
            cur_sel_q <= cur_sel_d;
            sel_q     <= sel_d;
            busy_q    <= busy_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
        end
    end

    assign bus.CE0     = ce_q[0];
    assign bus.S0      = ce_q[0];
    assign bus.CE1     = ce_q[1];
    assign bus.S1      = ce_q[1];
    assign bus.IGNORE0 = ign_q[0];
    assign bus.IGNORE1 = ign_q[1];
    assign bus.CUR_SEL = cur_sel_q;
    assign bus.BUSY    = busy_q;
    assign bus.ACK     = ack_q;
    assign bus.ERR     = err_q;
endmodule

// File: tb/tb_clkmux_sel_ctrl.sv
// Directed bench for clkmux_sel_ctrl with a response scoreboard on ACK/ERR.
module tb_clkmux_sel_ctrl;
    localparam int S = 4;
`ifdef CLKMUX_FORCE_SWITCH_EN
    localparam bit FORCE = 1'b1;
`else
    localparam bit FORCE = 1'b0;
`endif

    typedef struct {
        bit is_err;
        bit sel;
        int cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sbq[$];
    exp_t e;
    int   n;

    clkmux_sel_ctrl_if b0();
    clkmux_sel_ctrl_if b1();

    clkmux_sel_ctrl #(.SETTLE_CYCLES(S), .INIT_SEL(1'b0)) u0 (.CLK(clk), .RST_N(rst_n), .bus(b0));
    clkmux_sel_ctrl #(.SETTLE_CYCLES(S), .INIT_SEL(1'b1)) u1 (.CLK(clk), .RST_N(rst_n), .bus(b1));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic to_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic send(input bit sel);
        b0.REQ = 1'b1;
        b0.SEL = sel;
        @(negedge clk);
        b0.REQ = 1'b0;
    endtask

    // Mutual exclusion of the two mux inputs, every cycle.
    always @(negedge clk) begin
        assert (!(b0.CE0 && b0.CE1) && !(b0.S0 && b0.S1) && !(b1.CE0 && b1.CE1))
        else begin
            errors++;
            $display("FAIL ce_exclusive: got CE0=%0d CE1=%0d expected not both (cyc %0d)", b0.CE0, b0.CE1, cyc);
        end
    end

    // Response monitor.
    always @(negedge clk) begin
        if (rst_n && (b0.ACK || b0.ERR)) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp: got ack=%0d err=%0d at cyc %0d expected none", b0.ACK, b0.ERR, cyc);
            end else begin
                e = sbq.pop_front();
                chk("resp_ack", b0.ACK, !e.is_err);
                chk("resp_err", b0.ERR, e.is_err);
                chk("resp_cur_sel", b0.CUR_SEL, e.sel);
                chk("resp_cycle", cyc, e.cyc);
                chk("resp_busy", b0.BUSY, 0);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        b0.REQ = 0; b0.SEL = 0; b0.CLK0_OK = 1; b0.CLK1_OK = 1;
        b1.REQ = 0; b1.SEL = 0; b1.CLK0_OK = 1; b1.CLK1_OK = 1;
        repeat (3) @(negedge clk);

        chk("rst0_ce0", {b0.CE0, b0.S0}, 2'b11);
        chk("rst0_ce1", {b0.CE1, b0.S1}, 2'b00);
        chk("rst0_cur_sel", b0.CUR_SEL, 0);
        chk("rst0_status", {b0.BUSY, b0.ACK, b0.ERR, b0.IGNORE0, b0.IGNORE1}, 0);
        chk("rst1_ce0", {b1.CE0, b1.S0}, 2'b00);
        chk("rst1_ce1", {b1.CE1, b1.S1}, 2'b11);
        chk("rst1_cur_sel", b1.CUR_SEL, 1);
        chk("rst1_status", {b1.BUSY, b1.ACK, b1.ERR}, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Switch 0->1, both sources healthy.
        n = cyc + 1;
        sbq.push_back('{1'b0, 1'b1, n + 2*S});
        send(1'b1);
        chk("sw01_old_off", {b0.CE0, b0.S0, b0.CE1, b0.BUSY}, 4'b0001);
        to_cyc(n + S - 1);
        chk("sw01_gap", {b0.CE1, b0.CUR_SEL}, 2'b00);
        to_cyc(n + S);
        chk("sw01_new_on", {b0.CE1, b0.S1, b0.CUR_SEL, b0.BUSY}, 4'b1111);
        to_cyc(n + 2*S + 1);
        chk("sw01_idle", {b0.BUSY, b0.CE1}, 2'b01);

        // Same-source request; a REQ issued while in DONE must be dropped.
        n = cyc + 1;
        sbq.push_back('{1'b0, 1'b1, n});
        send(1'b1);
        chk("same_pins", {b0.CE0, b0.CE1, b0.BUSY}, 3'b010);
        send(1'b0);
        chk("done_req_ignored", {b0.CE0, b0.CE1, b0.BUSY}, 3'b010);
        @(negedge clk);
        chk("done_req_ignored2", {b0.BUSY, b0.CUR_SEL}, 2'b01);

        // Switch 1->0 with REQ hammered and SEL toggled while busy.
        n = cyc + 1;
        sbq.push_back('{1'b0, 1'b0, n + 2*S});
        b0.REQ = 1'b1; b0.SEL = 1'b0;
        for (int i = 0; i <= 2*S; i++) begin
            @(negedge clk);
            b0.SEL = ~b0.SEL;
        end
        b0.REQ = 1'b0;
        chk("hammer_final", {b0.CE0, b0.CE1, b0.CUR_SEL}, 3'b100);
        repeat (2) @(negedge clk);

        // Switch 0->1 into a dead source.
        b0.CLK1_OK = 1'b0;
        n = cyc + 1;
        sbq.push_back('{1'b1, 1'b1, n + 2*S});
        send(1'b1);
        to_cyc(n + 2*S + 1);
        chk("err_cur_sel", {b0.CUR_SEL, b0.CE1, b0.IGNORE0}, 3'b110);
        b0.CLK1_OK = 1'b1;

        // Back to 0, then leave a dead source 0.
        n = cyc + 1;
        sbq.push_back('{1'b0, 1'b0, n + 2*S});
        send(1'b0);
        to_cyc(n + 2*S + 1);
        b0.CLK0_OK = 1'b0;
        n = cyc + 1;
        sbq.push_back('{1'b0, 1'b1, n + 2*S});
        chk("ign_before", b0.IGNORE0, 0);
        send(1'b1);
        chk("ign_start", {b0.IGNORE0, b0.IGNORE1}, {FORCE, 1'b0});
        to_cyc(n + 2*S);
        chk("ign_done", {b0.IGNORE0, b0.IGNORE1}, {FORCE, 1'b0});
        @(negedge clk);
        chk("ign_cleared", {b0.IGNORE0, b0.IGNORE1}, 2'b00);
        b0.CLK0_OK = 1'b1;
        @(negedge clk);

        // Reset in the middle of a 1->0 switch: no response may follow.
        n = cyc + 1;
        b0.CLK1_OK = 1'b0;
        send(1'b0);
        to_cyc(n + 2);
        rst_n = 1'b0;
        #1;
        chk("midrst_pins", {b0.CE0, b0.S0, b0.CE1, b0.S1}, 4'b1100);
        chk("midrst_status", {b0.CUR_SEL, b0.BUSY, b0.ACK, b0.ERR, b0.IGNORE0, b0.IGNORE1}, 0);
        b0.CLK1_OK = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2*S + 4) @(negedge clk);
        chk("midrst_after", {b0.CE0, b0.CUR_SEL, b0.BUSY}, 3'b100);

        for (int i = 0; i < 20 && sbq.size() > 0; i++) @(negedge clk);
        chk("sb_drained", sbq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
